// File: rtl/nanci_cmd_sequencer.sv
// nanci_cmd_sequencer
// Broadcasts the neighbour-select opcode sequence for a shear-style mesh sort
// to every PE in an N x N array. The sequence is PHASES pairs of (row phase,
// column phase) followed by one final row phase. Each phase has N steps, and
// each step holds its opcode for SORT_CYCLES unstalled cycles.
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-low reset
//   i_start   start request, honoured only in IDLE
//   i_stall   freezes sequencing while a sequence is busy
//   i_abort   returns to IDLE next cycle; wins over start and stall
//   o_cmd     opcode: 0 NOP, 1 SLT_L, 2 SLT_R, 3 SLT_U, 4 SLT_D
//   o_strobe  first presented cycle of a step
//   o_phase   0 IDLE, 1 ROW, 2 COL, 3 FINAL_ROW
//   o_step    step index within the current phase
//   o_busy    sequence in progress
//   o_done    one-cycle completion pulse
// All outputs are registered.

module nanci_cmd_sequencer #(
   parameter int unsigned N           = 4,
   parameter int unsigned SORT_CYCLES = 1,
   parameter int unsigned PHASES      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic       i_stall,
   input  logic       i_abort,
   output logic [2:0] o_cmd,
   output logic       o_strobe,
   output logic [1:0] o_phase,
   output logic [7:0] o_step,
   output logic       o_busy,
   output logic       o_done
);

   localparam int unsigned CMD_W   = 3;
   localparam int unsigned PHASE_W = 2;
   localparam int unsigned STEP_W  = 8;
   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned PAIR_W  = 2;

   localparam logic [CMD_W-1:0] OP_NOP   = 3'd0;
   localparam logic [CMD_W-1:0] OP_SLT_L = 3'd1;
   localparam logic [CMD_W-1:0] OP_SLT_R = 3'd2;
   localparam logic [CMD_W-1:0] OP_SLT_U = 3'd3;
   localparam logic [CMD_W-1:0] OP_SLT_D = 3'd4;

   localparam logic [PHASE_W-1:0] PH_IDLE  = 2'd0;
   localparam logic [PHASE_W-1:0] PH_ROW   = 2'd1;
   localparam logic [PHASE_W-1:0] PH_COL   = 2'd2;
   localparam logic [PHASE_W-1:0] PH_FINAL = 2'd3;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);
   localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(SORT_CYCLES - 1);
   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PHASES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ROW       = 3'd1,
      S_COL       = 3'd2,
      S_FINAL_ROW = 3'd3,
      S_DONE      = 3'd4
   } state_e;

   // Sequencing state: (state, step, hold) names the item on the outputs now.
   state_e              state_q, state_d;
   logic [STEP_W-1:0]   step_q,  step_d;
   logic [HOLD_W-1:0]   hold_q,  hold_d;
   logic [PAIR_W-1:0]   pair_q,  pair_d;

   // Registered outputs.
   logic [CMD_W-1:0]    cmd_q,      cmd_d;
   logic                strobe_q,   strobe_d;
   logic [PHASE_W-1:0]  phase_q,    phase_d;
   logic [STEP_W-1:0]   out_step_q, out_step_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;

   // High when the next cycle presents a real command item (not a stall bubble).
   logic                present;

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      hold_d     = hold_q;
      pair_d     = pair_q;
      present    = 1'b0;
      cmd_d      = OP_NOP;
      strobe_d   = 1'b0;
      phase_d    = PH_IDLE;
      out_step_d = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      if (i_abort) begin
         state_d = S_IDLE;
         step_d  = '0;
         hold_d  = '0;
         pair_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_d = S_ROW;
                  step_d  = '0;
                  hold_d  = '0;
                  pair_d  = '0;
                  present = 1'b1;
               end
            end
            S_ROW, S_COL, S_FINAL_ROW: begin
               // A stalled edge leaves the position untouched; the item already
               // shown stays counted, so release moves on to the next item.
               if (!i_stall) begin
                  present = 1'b1;
                  if (hold_q != LAST_HOLD) begin
                     hold_d = hold_q + HOLD_W'(1);
                  end else begin
                     hold_d = '0;
                     if (step_q != LAST_STEP) begin
                        step_d = step_q + STEP_W'(1);
                     end else begin
                        step_d = '0;
                        case (state_q)
                           S_ROW: state_d = S_COL;
                           S_COL: begin
                              if (pair_q == LAST_PAIR) begin
                                 state_d = S_FINAL_ROW;
                              end else begin
                                 state_d = S_ROW;
                                 pair_d  = pair_q + PAIR_W'(1);
                              end
                           end
                           default: begin
                              state_d = S_DONE;
                              pair_d  = '0;
                           end
                        endcase
                     end
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs for the cycle following this edge.
      case (state_d)
         S_ROW, S_FINAL_ROW: begin
            busy_d     = 1'b1;
            phase_d    = (state_d == S_ROW) ? PH_ROW : PH_FINAL;
            out_step_d = step_d;
            if (present) begin
               cmd_d    = step_d[0] ? OP_SLT_L : OP_SLT_R;
               strobe_d = (hold_d == '0);
            end
         end
         S_COL: begin
            busy_d     = 1'b1;
            phase_d    = PH_COL;
            out_step_d = step_d;
            if (present) begin
               cmd_d    = step_d[0] ? OP_SLT_U : OP_SLT_D;
               strobe_d = (hold_d == '0);
            end
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         hold_q     <= '0;
         pair_q     <= '0;
         cmd_q      <= OP_NOP;
         strobe_q   <= 1'b0;
         phase_q    <= PH_IDLE;
         out_step_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         hold_q     <= hold_d;
         pair_q     <= pair_d;
         cmd_q      <= cmd_d;
         strobe_q   <= strobe_d;
         phase_q    <= phase_d;
         out_step_q <= out_step_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign o_cmd    = cmd_q;
   assign o_strobe = strobe_q;
   assign o_phase  = phase_q;
   assign o_step   = out_step_q;
   assign o_busy   = busy_q;
   assign o_done   = done_q;

endmodule

// File: doc/nanci_cmd_sequencer.md
NANCI_CMD_SEQUENCER -- requirements
Module: nanci_cmd_sequencer

Interface
REQ-001 Parameter N, default 4: mesh side length; steps per sort phase; 2..255.
REQ-002 Parameter SORT_CYCLES, default 1: cycles each step command is held; 1..255.
REQ-003 Parameter PHASES, default 2: number of row+column phase pairs before the final row phase; 1..3.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 i_start  input  1  start request, sampled only in IDLE.
REQ-007 i_stall  input  1  freeze sequencing while high.
REQ-008 i_abort  input  1  terminate sequence, return to IDLE.
REQ-009 o_cmd  output  3  neighbour-select opcode driven to all PEs.
REQ-010 o_strobe  output  1  high on the first cycle a new step command is presented.
REQ-011 o_phase  output  2  0 IDLE, 1 ROW, 2 COL, 3 FINAL_ROW.
REQ-012 o_step  output  8  index of current step within the phase, 0..N-1.
REQ-013 o_busy  output  1  high while a sequence is in progress.
REQ-014 o_done  output  1  one-cycle pulse on sequence completion.

Function
REQ-015 Opcodes SHALL be: 0 NOP, 1 SLT_L, 2 SLT_R, 3 SLT_U, 4 SLT_D; values 5..7 are never driven.
REQ-016 FSM states SHALL be IDLE, ROW, COL, FINAL_ROW, DONE.
REQ-017 IDLE: o_cmd=NOP, o_busy=0, o_phase=0; i_start=1 with i_abort=0 -> ROW next cycle, step 0, pair count 0.
REQ-018 ROW and FINAL_ROW steps: even step -> SLT_R, odd step -> SLT_L.
REQ-019 COL steps: even step -> SLT_D, odd step -> SLT_U.
REQ-020 Each step's o_cmd SHALL be held for exactly SORT_CYCLES unstalled cycles; o_strobe high only on the first of them.
REQ-021 After step N-1 completes: ROW -> COL; COL -> ROW with pair count +1 if pair count+1 < PHASES, else -> FINAL_ROW; FINAL_ROW -> DONE; step resets to 0.
REQ-022 DONE SHALL last one cycle: o_done=1, o_cmd=NOP, o_busy=0, o_phase=0; then IDLE.
REQ-023 o_busy SHALL be 1 in ROW, COL and FINAL_ROW only.
REQ-024 i_stall=1 while busy: step counter, hold counter and state frozen; o_cmd forced NOP, o_strobe 0; o_phase and o_step held; on release the interrupted step resumes with its remaining hold cycles and no new strobe, unless no cycle of it had yet been presented, in which case strobe is reissued.
REQ-025 i_start while busy or in DONE SHALL be ignored.
REQ-026 i_abort=1 in any state SHALL force IDLE next cycle without asserting o_done; abort takes priority over start and stall.
REQ-027 Total unstalled busy cycles SHALL be (2*PHASES+1)*N*SORT_CYCLES.
REQ-028 All outputs SHALL be registered; latency from i_start sampled to first o_strobe is one cycle.

Reset
REQ-029 rst=0 on a rising edge SHALL force IDLE, counters to 0 and o_cmd=0, o_strobe=0, o_phase=0, o_step=0, o_busy=0, o_done=0 on the following cycle, regardless of state or other inputs.
REQ-030 Reset mid-sequence SHALL discard all progress; no o_done pulse is emitted.
REQ-031 Outputs SHALL hold reset values until the first i_start after rst returns to 1.

Verification
REQ-032 N=2, SORT_CYCLES=1, PHASES=1; pulse i_start -> o_cmd 2,1,4,3,2,1 on six consecutive cycles, o_strobe high each cycle, o_phase 1,1,2,2,3,3, then o_done=1 for one cycle with o_cmd=0.
REQ-033 N=2, SORT_CYCLES=3, PHASES=1 -> each opcode held 3 cycles, o_strobe on cycles 0,3,6,9,12,15; o_busy high 18 cycles.
REQ-034 N=2, SORT_CYCLES=1: i_stall high 2 cycles during step 1 of COL -> o_cmd=0 while stalled, then 3 (SLT_U) resumes; completion delayed by exactly 2 cycles.
REQ-035 i_abort asserted during COL -> IDLE next cycle, o_busy=0, o_done never pulses; a new i_start restarts at ROW step 0 with o_cmd=2.
REQ-036 rst=0 for one cycle during FINAL_ROW -> all outputs 0 next cycle; i_start pulses while busy produce no restart or sequence change.
REQ-037 N=3, SORT_CYCLES=1, PHASES=2 -> 15 commands: R,L,R / D,U,D / R,L,R / D,U,D / R,L,R; o_step wraps 0,1,2 per phase.
